mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port 1024x32 data/instruction memory between the instruction-fetch port (read-only) and the load/store port (read/write). It accepts valid/ready requests, converts byte addresses to word addresses, and drives the memory's address, rw_mode, write data and byte enables. It returns read data to the granted requester one cycle after grant, because the memory's read data is registered. A starvation counter guarantees fetch progress under sustained load/store traffic.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_starve_cnt.sv | 43 ++++
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types, constants and helpers for the instruction/data memory arbiter.
package mem_arb_pkg;

    // Which requester owns the response slot in the cycle after a grant.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } owner_e;

    // Memory rw_mode value that never writes.
    localparam logic MEM_IDLE_RW = 1'b1;

    // True when a byte address is word-aligned and inside a 2**addr_w word memory.
    function automatic logic word_addr_ok(input logic [31:0] addr, input int unsigned addr_w);
        return ((addr >> (addr_w + 32'd2)) == 32'd0) && (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Saturating count of consecutive cycles the fetch port was refused.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   if_valid       fetch request pending this cycle
//   if_grant       fetch granted this cycle
//   force_grant    fetch has waited MAX_WAIT cycles and must win next
module mem_arb_starve_cnt #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic if_valid,
    input  logic if_grant,
    output logic force_grant
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] cnt_next;

    // Clear when fetch is served or withdraws, otherwise count up to the limit.
    always_comb begin
        cnt_next = wait_cnt;
        if (!if_valid || if_grant) begin
            cnt_next = '0;
        end else if (wait_cnt != CNT_W'(MAX_WAIT)) begin
            cnt_next = wait_cnt + CNT_W'(1);
        end
    end

    // force_grant is registered alongside the count so it equals (wait_cnt == MAX_WAIT).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wait_cnt    <= '0;
            force_grant <= 1'b0;
        end else begin
            wait_cnt    <= cnt_next;
            force_grant <= (cnt_next == CNT_W'(MAX_WAIT));
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-port registered-read memory between instruction fetch
// (read-only) and load/store (read/write) requesters.
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   in_if_*/out_if_*              fetch request (valid/addr/ready) and response
//   in_ls_*/out_ls_*              load/store request and response
//   out_mem_*                     memory address, rw_mode (1=read), write data, byte enables
//   in_mem_data                   memory read data, valid the cycle after the address
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              in_if_valid,
    input  logic [31:0]       in_if_addr,
    output logic              out_if_ready,
    output logic              out_if_rsp_valid,
    output logic [31:0]       out_if_rsp_data,
    output logic              out_if_rsp_err,
    input  logic              in_ls_valid,
    input  logic              in_ls_write,
    input  logic [31:0]       in_ls_addr,
    input  logic [31:0]       in_ls_wdata,
    input  logic [3:0]        in_ls_byte_en,
    output logic              out_ls_ready,
    output logic              out_ls_rsp_valid,
    output logic [31:0]       out_ls_rsp_data,
    output logic              out_ls_rsp_err,
    output logic [ADDR_W-1:0] out_mem_addr,
    output logic              out_mem_rw_mode,
    output logic [31:0]       out_mem_write_data,
    output logic [3:0]        out_mem_byte_en,
    input  logic [31:0]       in_mem_data
);

    logic              force_grant;
    logic              if_grant;
    logic              ls_grant;
    logic              if_ok;
    logic              ls_ok;
    logic [ADDR_W-1:0] if_waddr;
    logic [ADDR_W-1:0] ls_waddr;
    logic [ADDR_W-1:0] last_addr_q;
    owner_e            rsp_owner_q;
    logic              rsp_is_store_q;
    logic              rsp_err_q;

    assign if_ok    = word_addr_ok(in_if_addr, ADDR_W);
    assign ls_ok    = word_addr_ok(in_ls_addr, ADDR_W);
    assign if_waddr = in_if_addr[ADDR_W+1:2];
    assign ls_waddr = in_ls_addr[ADDR_W+1:2];

    mem_arb_starve_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_cnt (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .if_valid    (in_if_valid),
        .if_grant    (if_grant),
        .force_grant (force_grant)
    );

    // Grant selection and memory drive; load/store wins unless fetch is starved.
    always_comb begin
        if_grant           = 1'b0;
        ls_grant           = 1'b0;
        out_mem_addr       = last_addr_q;
        out_mem_rw_mode    = MEM_IDLE_RW;
        out_mem_write_data = '0;
        out_mem_byte_en    = '0;

        if (!i_rst) begin
            if (in_if_valid && (force_grant || !in_ls_valid)) begin
                if_grant = 1'b1;
            end else if (in_ls_valid) begin
                ls_grant = 1'b1;
            end
        end

        // Out-of-range requests are accepted but never reach the memory.
        if (if_grant && if_ok) begin
            out_mem_addr = if_waddr;
        end
        if (ls_grant && ls_ok) begin
            out_mem_addr = ls_waddr;
            if (in_ls_write) begin
                out_mem_rw_mode    = 1'b0;
                out_mem_write_data = in_ls_wdata;
                out_mem_byte_en    = in_ls_byte_en;
            end
        end
    end

    assign out_if_ready = if_grant;
    assign out_ls_ready = ls_grant;

    // Response slot captured at grant; last address held for idle cycles.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_addr_q    <= '0;
            rsp_owner_q    <= OWN_NONE;
            rsp_is_store_q <= 1'b0;
            rsp_err_q      <= 1'b0;
        end else begin
            last_addr_q <= out_mem_addr;
            if (if_grant) begin
                rsp_owner_q    <= OWN_IF;
                rsp_is_store_q <= 1'b0;
                rsp_err_q      <= !if_ok;
            end else if (ls_grant) begin
                rsp_owner_q    <= OWN_LS;
                rsp_is_store_q <= in_ls_write;
                rsp_err_q      <= !ls_ok;
            end else begin
                rsp_owner_q    <= OWN_NONE;
                rsp_is_store_q <= 1'b0;
                rsp_err_q      <= 1'b0;
            end
        end
    end

    // Responses are suppressed while reset is held so an in-flight one is dropped.
    always_comb begin
        out_if_rsp_valid = !i_rst && (rsp_owner_q == OWN_IF);
        out_ls_rsp_valid = !i_rst && (rsp_owner_q == OWN_LS);
        out_if_rsp_err   = out_if_rsp_valid && rsp_err_q;
        out_ls_rsp_err   = out_ls_rsp_valid && rsp_err_q;
        out_if_rsp_data  = (out_if_rsp_valid && !rsp_err_q) ? in_mem_data : 32'd0;
        out_ls_rsp_data  = (out_ls_rsp_valid && !rsp_err_q && !rsp_is_store_q) ? in_mem_data : 32'd0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 1024x32 registered-read memory model.
module tb_mem_arbiter;

    localparam int unsigned ADDR_W   = 10;
    localparam int unsigned MAX_WAIT = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              mem_clear = 1'b1;
    logic              if_valid = 1'b0;
    logic [31:0]       if_addr = '0;
    logic              if_ready;
    logic              if_rsp_valid;
    logic [31:0]       if_rsp_data;
    logic              if_rsp_err;
    logic              ls_valid = 1'b0;
    logic              ls_write = 1'b0;
    logic [31:0]       ls_addr = '0;
    logic [31:0]       ls_wdata = '0;
    logic [3:0]        ls_be = '0;
    logic              ls_ready;
    logic              ls_rsp_valid;
    logic [31:0]       ls_rsp_data;
    logic              ls_rsp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rw;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic [31:0]       mem_rdata;
    logic [31:0]       mem [0:1023];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W   (ADDR_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .in_if_valid        (if_valid),
        .in_if_addr         (if_addr),
        .out_if_ready       (if_ready),
        .out_if_rsp_valid   (if_rsp_valid),
        .out_if_rsp_data    (if_rsp_data),
        .out_if_rsp_err     (if_rsp_err),
        .in_ls_valid        (ls_valid),
        .in_ls_write        (ls_write),
        .in_ls_addr         (ls_addr),
        .in_ls_wdata        (ls_wdata),
        .in_ls_byte_en      (ls_be),
        .out_ls_ready       (ls_ready),
        .out_ls_rsp_valid   (ls_rsp_valid),
        .out_ls_rsp_data    (ls_rsp_data),
        .out_ls_rsp_err     (ls_rsp_err),
        .out_mem_addr       (mem_addr),
        .out_mem_rw_mode    (mem_rw),
        .out_mem_write_data (mem_wdata),
        .out_mem_byte_en    (mem_be),
        .in_mem_data        (mem_rdata)
    );

    // Memory: writes enabled lanes whenever rw_mode=0, read data registered.
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 1024; i++) mem[i] <= '0;
            mem_rdata <= '0;
        end else begin
            if (!mem_rw) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
            mem_rdata <= mem[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Apply inputs at the falling edge; outputs are checked 1 time unit later.
    task automatic drive(input logic r, input logic ifv, input logic [31:0] ifa,
                         input logic lsv, input logic lsw, input logic [31:0] lsa,
                         input logic [31:0] wd, input logic [3:0] be);
        @(negedge clk);
        rst = r; if_valid = ifv; if_addr = ifa;
        ls_valid = lsv; ls_write = lsw; ls_addr = lsa; ls_wdata = wd; ls_be = be;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic chk_rdy(input string tag, input logic ifr, input logic lsr);
        chk({tag, ".if_ready"}, 32'(if_ready), 32'(ifr));
        chk({tag, ".ls_ready"}, 32'(ls_ready), 32'(lsr));
    endtask

    task automatic chk_mem_idle(input string tag);
        chk({tag, ".rw_mode"}, 32'(mem_rw), 32'd1);
        chk({tag, ".byte_en"}, 32'(mem_be), 32'd0);
    endtask

    task automatic chk_if_rsp(input string tag, input logic v, input logic e, input logic [31:0] d);
        chk({tag, ".if_rsp_valid"}, 32'(if_rsp_valid), 32'(v));
        chk({tag, ".if_rsp_err"}, 32'(if_rsp_err), 32'(e));
        chk({tag, ".if_rsp_data"}, if_rsp_data, d);
    endtask

    task automatic chk_ls_rsp(input string tag, input logic v, input logic e, input logic [31:0] d);
        chk({tag, ".ls_rsp_valid"}, 32'(ls_rsp_valid), 32'(v));
        chk({tag, ".ls_rsp_err"}, 32'(ls_rsp_err), 32'(e));
        chk({tag, ".ls_rsp_data"}, ls_rsp_data, d);
    endtask

    initial begin
        logic [11:0] starve_if_pat;
        logic [8:0]  clr_ifv;
        logic [8:0]  clr_if_pat;
        logic        prev_if;
        logic        prev_ls;

        // Held in reset with both requesters asking: nothing granted, nothing written.
        drive(1'b1, 1'b1, 32'h0, 1'b1, 1'b1, 32'h10, 32'hFFFFFFFF, 4'hF);
        chk_rdy("rst0", 1'b0, 1'b0);
        chk_mem_idle("rst0");
        chk_ls_rsp("rst0", 1'b0, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        mem_clear = 1'b0;

        // Ten idle cycles after reset.
        for (int i = 0; i < 10; i++) begin
            idle();
            chk_mem_idle("idle");
            chk("idle.if_rsp_valid", 32'(if_rsp_valid), 32'd0);
            chk("idle.ls_rsp_valid", 32'(ls_rsp_valid), 32'd0);
            if (i == 0) chk("idle.mem_addr", 32'(mem_addr), 32'd0);
        end

        // Read back address 0 after idle.
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        chk_rdy("rd0", 1'b0, 1'b1);

        // Partial store then load of the same word on the next cycle.
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'b0011);
        chk_ls_rsp("rd0.rsp", 1'b1, 1'b0, 32'h0);
        chk_rdy("st", 1'b0, 1'b1);
        chk("st.rw_mode", 32'(mem_rw), 32'd0);
        chk("st.byte_en", 32'(mem_be), 32'h3);
        chk("st.wdata", mem_wdata, 32'hDEADBEEF);
        chk("st.mem_addr", 32'(mem_addr), 32'd4);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        chk_ls_rsp("st.rsp", 1'b1, 1'b0, 32'h0);
        chk_rdy("ld", 1'b0, 1'b1);
        chk_mem_idle("ld");
        chk("ld.wdata", mem_wdata, 32'h0);
        idle();
        chk_ls_rsp("ld.rsp", 1'b1, 1'b0, 32'h0000BEEF);
        chk("idle.hold_addr", 32'(mem_addr), 32'd4);
        chk_mem_idle("idle2");

        // Preload words 0..2 with 1, 2, 3 through the store path.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'(4 * i), 32'(i + 1), 4'hF);
            chk_rdy("pre", 1'b0, 1'b1);
        end

        // Back-to-back fetches, data streams out one cycle behind each grant.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 32'(4 * i), 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            chk_rdy("bb", 1'b1, 1'b0);
            chk("bb.mem_addr", 32'(mem_addr), 32'(i));
            if (i == 0) chk_ls_rsp("pre.rsp", 1'b1, 1'b0, 32'h0);
            else chk_if_rsp("bb.rsp", 1'b1, 1'b0, 32'(i));
        end
        idle();
        chk_if_rsp("bb.rsp3", 1'b1, 1'b0, 32'd3);
        idle();
        chk_if_rsp("bb.done", 1'b0, 1'b0, 32'h0);

        // Sustained contention: fetch forced through on cycles 5 and 10.
        starve_if_pat = 12'b0010_0001_0000;
        prev_if = 1'b0;
        prev_ls = 1'b0;
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
            chk_rdy("starve", starve_if_pat[i], !starve_if_pat[i]);
            chk("starve.mem_addr", 32'(mem_addr), starve_if_pat[i] ? 32'd0 : 32'd4);
            chk_if_rsp("starve.if", prev_if, 1'b0, prev_if ? 32'd1 : 32'd0);
            chk_ls_rsp("starve.ls", prev_ls, 1'b0, prev_ls ? 32'h0000BEEF : 32'd0);
            prev_if = starve_if_pat[i];
            prev_ls = !starve_if_pat[i];
        end
        idle();
        chk_ls_rsp("starve.last", 1'b1, 1'b0, 32'h0000BEEF);
        chk("starve.last.if", 32'(if_rsp_valid), 32'd0);

        // Out-of-range load, misaligned fetch, out-of-range store.
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h1000, 32'h0, 4'h0);
        chk_rdy("oor_ld", 1'b0, 1'b1);
        chk_mem_idle("oor_ld");
        chk("oor_ld.mem_addr", 32'(mem_addr), 32'd4);
        drive(1'b0, 1'b1, 32'h6, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        chk_ls_rsp("oor_ld.rsp", 1'b1, 1'b1, 32'h0);
        chk_rdy("mis_if", 1'b1, 1'b0);
        chk_mem_idle("mis_if");
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF);
        chk_if_rsp("mis_if.rsp", 1'b1, 1'b1, 32'h0);
        chk_rdy("oor_st", 1'b0, 1'b1);
        chk_mem_idle("oor_st");
        chk("oor_st.wdata", mem_wdata, 32'h0);
        idle();
        chk_ls_rsp("oor_st.rsp", 1'b1, 1'b1, 32'h0);

        // Dropping fetch valid clears the wait count before the limit is reached.
        clr_ifv    = 9'b1_1111_0111;
        clr_if_pat = 9'b1_0000_0000;
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, clr_ifv[i], 32'h0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
            chk_rdy("clr", clr_if_pat[i], !clr_if_pat[i]);
        end
        idle();
        chk_if_rsp("clr.rsp", 1'b1, 1'b0, 32'd1);

        // Reset right after a grant drops the pending response.
        idle();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
        chk_rdy("rst_ld", 1'b0, 1'b1);
        chk("rst_ld.mem_addr", 32'(mem_addr), 32'd2);
        drive(1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
        chk_rdy("rst_hold", 1'b0, 1'b0);
        chk_mem_idle("rst_hold");
        chk_ls_rsp("rst_hold", 1'b0, 1'b0, 32'h0);
        chk_if_rsp("rst_hold", 1'b0, 1'b0, 32'h0);
        idle();
        chk_ls_rsp("rst_post", 1'b0, 1'b0, 32'h0);
        chk_if_rsp("rst_post", 1'b0, 1'b0, 32'h0);
        chk("rst_post.mem_addr", 32'(mem_addr), 32'd0);
        chk_mem_idle("rst_post");
        idle();
        chk("rst_post2.ls_rsp_valid", 32'(ls_rsp_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
